// File: rtl/aes_ct_serializer.sv
// Capture FIFO for AES blocks: registered head, push accepted when not full or when popping the same cycle.
// One-cycle write-to-head latency; pushes beyond DEPTH are refused and left to the caller to flag.
module ct_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NSLOT = 1 << AW;

  logic [W-1:0]  mem [NSLOT];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop_vld && !empty;
  assign push_ok  = push_vld && (!full || pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Streams captured 128-bit AES ciphertext blocks MSB-first as OUT_W-bit beats; first beat 2 clocks after capture.
// Beats hold stable while m_ready is low; blocks arriving with the FIFO full are dropped and flagged in overflow.
module aes_ct_serializer #(
  parameter int OUT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             blk_valid,
  input  logic [127:0]     blk_data,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       blk_count
);
  localparam int BEATS = 128 / OUT_W;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic           blk_prev, cap_vld;
  logic           fifo_empty, fifo_full, pop_vld;
  logic           beat_hs, beat_last;
  logic [127:0]   head_dat, shreg;
  logic [IW-1:0]  beat_idx;

  assign cap_vld   = blk_valid && !blk_prev;
  assign beat_last = (beat_idx == IW'(BEATS - 1));
  assign beat_hs   = (state == SHIFT) && m_ready;
  // Load from IDLE, or chain the next block on the final handshake so there is no bubble.
  assign pop_vld   = !fifo_empty && ((state == IDLE) || (beat_hs && beat_last));

  ct_fifo #(.W(128), .DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push_vld (cap_vld),
    .push_dat (blk_data),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SHIFT;
      SHIFT:   if (beat_hs && beat_last && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state == SHIFT);
    m_last  = m_valid && beat_last;
    m_data  = m_valid ? shreg[127 -: OUT_W] : '0;
    busy    = !fifo_empty || m_valid;
  end

  // Edge register resets high so a level already asserted at reset release is not taken as a new block.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      blk_prev  <= 1'b1;
      shreg     <= '0;
      beat_idx  <= '0;
      blk_count <= '0;
      overflow  <= 1'b0;
    end else begin
      blk_prev <= blk_valid;
      if (cap_vld && fifo_full && !pop_vld) overflow <= 1'b1;
      if (pop_vld) begin
        shreg    <= head_dat;
        beat_idx <= '0;
      end else if (beat_hs && !beat_last) begin
        shreg    <= shreg << OUT_W;
        beat_idx <= beat_idx + 1'b1;
      end
      if (beat_hs && beat_last) blk_count <= blk_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed bench for aes_ct_serializer: 8-bit build for the main scenarios, 32-bit build for beat width.
module tb_aes_ct_serializer;
  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         m_ready = 1'b0;
  logic [127:0] blk_data = '0;

  logic [7:0]  m_data;
  logic        m_valid, m_last, overflow, busy;
  logic [7:0]  blk_count;
  logic [31:0] m_data32;
  logic        m_valid32, m_last32, overflow32, busy32;
  logic [7:0]  blk_count32;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_dat [$];
  logic       got_last [$];
  int         gaps, hold_viol, first_vld;

  localparam logic [127:0] BLK_A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BLK_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK_C = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] BLK_D = 128'hdeadbeefcafef00d0123456789abcdef;

  logic [127:0] blks [4] = '{BLK_A, BLK_B, BLK_C, BLK_D};
  logic [7:0]   exp_a [16] = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                               8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
  logic [31:0]  exp32 [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

  aes_ct_serializer #(.OUT_W(8), .DEPTH(2)) dut (
    .CLK(CLK), .reset(reset), .blk_valid(blk_valid), .blk_data(blk_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overflow(overflow), .busy(busy), .blk_count(blk_count)
  );

  aes_ct_serializer #(.OUT_W(32), .DEPTH(2)) dut32 (
    .CLK(CLK), .reset(reset), .blk_valid(blk_valid), .blk_data(blk_data),
    .m_data(m_data32), .m_valid(m_valid32), .m_ready(m_ready), .m_last(m_last32),
    .overflow(overflow32), .busy(busy32), .blk_count(blk_count32)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int i);
    return blk[127 - 8*i -: 8];
  endfunction

  task automatic do_reset;
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0 repeating.
  task automatic collect(input int nbeats, input int max_cyc, input int mode);
    logic [7:0] prev_dat;
    logic       prev_stall;
    logic       started;
    got_dat.delete();
    got_last.delete();
    gaps = 0; hold_viol = 0; first_vld = -1;
    prev_stall = 1'b0; prev_dat = '0; started = 1'b0;
    for (int c = 0; c < max_cyc && got_dat.size() < nbeats; c++) begin
      @(negedge CLK);
      m_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (prev_stall && (m_data !== prev_dat)) hold_viol++;
      if (m_valid) begin
        if (!started) first_vld = c;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      if (m_valid && m_ready) begin
        got_dat.push_back(m_data);
        got_last.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_dat   = m_data;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00)   begin n_err++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (blk_count !== 8'd0) begin n_err++; $display("FAIL rst_blk_count: got %0d want 0", blk_count); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    blk_data = BLK_A; blk_valid = 1'b1;
    collect(16, 60, 0);
    blk_valid = 1'b0;
    n_cmp++; if (first_vld !== 1) begin n_err++; $display("FAIL single_latency: first valid at cycle %0d want 1", first_vld); end
    n_cmp++; if (got_dat.size() !== 16) begin n_err++; $display("FAIL single_beats: got %0d want 16", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_cmp++; if (got_dat[i] !== exp_a[i]) begin n_err++; $display("FAIL single_data[%0d]: got %h want %h", i, got_dat[i], exp_a[i]); end
      n_cmp++; if (got_last[i] !== (i == 15)) begin n_err++; $display("FAIL single_last[%0d]: got %b want %b", i, got_last[i], (i == 15)); end
    end
    @(negedge CLK);
    n_cmp++; if (blk_count !== 8'd1) begin n_err++; $display("FAIL single_blk_count: got %0d want 1", blk_count); end
    n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL single_idle_valid: got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b0;
    @(negedge CLK);
    blk_data = BLK_A; blk_valid = 1'b1;
    collect(16, 120, 1);
    blk_valid = 1'b0;
    n_cmp++; if (got_dat.size() !== 16) begin n_err++; $display("FAIL bp_beats: got %0d want 16", got_dat.size()); end
    n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL bp_hold: got %0d changes under stall want 0", hold_viol); end
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL bp_valid_drop: got %0d drops want 0", gaps); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_cmp++; if (got_dat[i] !== exp_a[i]) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_dat[i], exp_a[i]); end
    end
    @(negedge CLK);
    n_cmp++; if (blk_count !== 8'd1) begin n_err++; $display("FAIL bp_blk_count: got %0d want 1", blk_count); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    fork
      begin
        for (int e = 0; e < 3; e++) begin
          blk_data = blks[e]; blk_valid = 1'b1;
          @(negedge CLK);
          blk_valid = 1'b0;
          repeat (3) @(negedge CLK);
        end
      end
      collect(48, 150, 0);
    join
    n_cmp++; if (got_dat.size() !== 48) begin n_err++; $display("FAIL b2b_beats: got %0d want 48", got_dat.size()); end
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_gap: got %0d idle cycles want 0", gaps); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_cmp++; if (got_dat[i] !== exp_byte(blks[i/16], i%16)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_dat[i], exp_byte(blks[i/16], i%16)); end
      n_cmp++; if (got_last[i] !== ((i % 16) == 15)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", i, got_last[i], ((i % 16) == 15)); end
    end
    @(negedge CLK);
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    n_cmp++; if (blk_count !== 8'd3) begin n_err++; $display("FAIL b2b_blk_count: got %0d want 3", blk_count); end
  endtask

  task automatic test_overflow;
    int extra;
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b0;
    @(negedge CLK);
    for (int e = 0; e < 4; e++) begin
      blk_data = blks[e]; blk_valid = 1'b1;
      @(negedge CLK);
      blk_valid = 1'b0;
      @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (m_valid !== 1'b1)   begin n_err++; $display("FAIL ovf_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h39)   begin n_err++; $display("FAIL ovf_head: got %h want 39", m_data); end
    n_cmp++; if (blk_count !== 8'd0) begin n_err++; $display("FAIL ovf_count_stalled: got %0d want 0", blk_count); end
    collect(48, 150, 0);
    n_cmp++; if (got_dat.size() !== 48) begin n_err++; $display("FAIL ovf_beats: got %0d want 48", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_cmp++; if (got_dat[i] !== exp_byte(blks[i/16], i%16)) begin n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", i, got_dat[i], exp_byte(blks[i/16], i%16)); end
    end
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (m_valid) extra++;
    end
    n_cmp++; if (extra !== 0)        begin n_err++; $display("FAIL ovf_extra_beats: got %0d want 0", extra); end
    n_cmp++; if (blk_count !== 8'd3) begin n_err++; $display("FAIL ovf_blk_count: got %0d want 3", blk_count); end
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_hold;
    int seen;
    blk_valid = 1'b1; blk_data = BLK_B; m_ready = 1'b0;
    do_reset();
    seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (m_valid) seen++;
    end
    n_cmp++; if (seen !== 0)     begin n_err++; $display("FAIL hold_no_capture: got %0d valid cycles want 0", seen); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL hold_busy: got %b want 0", busy); end
    blk_valid = 1'b0;
    @(negedge CLK);
    blk_valid = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL hold_fresh_edge: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL hold_fresh_data: got %h want 00", m_data); end
    collect(16, 60, 0);
    blk_valid = 1'b0;
    n_cmp++; if (got_dat.size() !== 16) begin n_err++; $display("FAIL hold_drain: got %0d want 16", got_dat.size()); end
  endtask

  task automatic test_reset_midblock;
    int seen;
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    blk_data = BLK_A; blk_valid = 1'b1;
    collect(7, 40, 0);
    @(negedge CLK);
    n_cmp++; if (m_data !== 8'hfb) begin n_err++; $display("FAIL mid_beat7: got %h want fb", m_data); end
    reset = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00)   begin n_err++; $display("FAIL mid_rst_data: got %h want 00", m_data); end
    n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL mid_rst_last: got %b want 0", m_last); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (blk_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", blk_count); end
    blk_valid = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (m_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_quiet: got %0d valid cycles want 0", seen); end
    blk_data = BLK_A; blk_valid = 1'b1;
    collect(16, 60, 0);
    blk_valid = 1'b0;
    n_cmp++; if (got_dat.size() !== 16) begin n_err++; $display("FAIL mid_restart_beats: got %0d want 16", got_dat.size()); end
    if (got_dat.size() > 0) begin
      n_cmp++; if (got_dat[0] !== 8'h39) begin n_err++; $display("FAIL mid_restart_first: got %h want 39", got_dat[0]); end
    end
    @(negedge CLK);
    n_cmp++; if (blk_count !== 8'd1) begin n_err++; $display("FAIL mid_restart_count: got %0d want 1", blk_count); end
  endtask

  task automatic test_out32;
    logic [31:0] q32 [$];
    logic        l32 [$];
    do_reset();
    blk_valid = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    blk_data = BLK_A; blk_valid = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (m_valid32) begin
        q32.push_back(m_data32);
        l32.push_back(m_last32);
      end
    end
    blk_valid = 1'b0;
    n_cmp++; if (q32.size() !== 4) begin n_err++; $display("FAIL w32_beats: got %0d want 4", q32.size()); end
    for (int i = 0; i < q32.size() && i < 4; i++) begin
      n_cmp++; if (q32[i] !== exp32[i]) begin n_err++; $display("FAIL w32_data[%0d]: got %h want %h", i, q32[i], exp32[i]); end
      n_cmp++; if (l32[i] !== (i == 3)) begin n_err++; $display("FAIL w32_last[%0d]: got %b want %b", i, l32[i], (i == 3)); end
    end
    n_cmp++; if (blk_count32 !== 8'd1) begin n_err++; $display("FAIL w32_blk_count: got %0d want 1", blk_count32); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_hold();
    test_reset_midblock();
    test_out32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
- Downstream of the AES encryption core.
- Captures each finished 128-bit ciphertext block on the core's ready/done level signal, using rising-edge detection.
- Buffers up to DEPTH blocks, then streams each block MSB-first as OUT_W-bit beats over a valid/ready handshake to the byte-oriented output path (UART/host interface).

Parameters:
- OUT_W, 8, beat width in bits; must divide 128 (legal: 8, 16, 32, 64).
- DEPTH, 2, number of 128-bit blocks the capture FIFO holds (power of two, ≥1).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- blk_valid  input  1  AES core ready level; each low→high transition marks one new block.
- blk_data  input  128  AES core ciphertext; sampled in the cycle the rising edge is detected.
- m_data  output  OUT_W  current beat; [OUT_W-1:0] = next-most-significant slice of block.
- m_valid  output  1  beat valid.
- m_ready  input  1  sink accepts beat when m_valid & m_ready at posedge.
- m_last  output  1  high with final beat of a block.
- overflow  output  1  sticky; block dropped because FIFO full.
- busy  output  1  high when FIFO non-empty or m_valid high.
- blk_count  output  8  count of blocks fully transmitted; wraps 255→0.

Behaviour:
- Reset (async, active-high): m_data=0, m_valid=0, m_last=0, overflow=0, busy=0, blk_count=0, FIFO empty, FSM=IDLE, beat index=0. The edge-detect register resets to 1, so blk_valid held high across reset release does not capture; a fresh 0→1 is required.
- Edge detect: capture when blk_valid=1 and prev=0 at the same posedge. prev <= blk_valid every cycle.
- FIFO push on capture:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the block is discarded and overflow is set (stays 1 until reset).
  - Simultaneous push and pop keeps count unchanged.
- FSM states IDLE, SHIFT:
  - IDLE: if FIFO non-empty, pop head into a 128-bit shift register, beat index=0, m_valid<=1, go SHIFT. Otherwise m_valid=0.
  - SHIFT: m_data = shreg[127:128-OUT_W]. m_last = (beat index == 128/OUT_W-1).
  - SHIFT, on a non-last handshake: shreg <<= OUT_W, beat index++.
  - SHIFT, on the last handshake: blk_count++. If FIFO non-empty, load the next block in the same edge (no bubble, m_valid stays 1, index=0). Else m_valid<=0, go IDLE.
  - SHIFT, with m_valid=1 and m_ready=0: m_data, m_last, and shreg hold stable. m_valid never drops without a handshake.
- Latency:
  - Capture edge at cycle N with FIFO empty and FSM IDLE → head written at N.
  - Pop/load at N+1; m_valid high and first beat on m_data after N+1 edge.
  - Capture-to-first-beat = 2 clocks.
- Throughput: with m_ready tied high, one block every 128/OUT_W cycles; back-to-back blocks have no idle cycle.
- Byte order: first beat = blk_data[127:128-OUT_W]; last beat = blk_data[OUT_W-1:0]. For OUT_W=8 this is FIPS-197 output byte order.
- An edge in the same cycle as the FIFO becoming empty via pop goes through the normal push path. No combinational path from blk_data to m_data.
- Reset mid-block: the beat in flight is abandoned, all buffered blocks are lost, and no m_last is issued.

Test Plan:
- Single block: blk_data=128'h3925841d02dc09fbdc118597196a0b32, blk_valid 0→1, m_ready=1.
  - m_valid rises 2 clocks after the edge.
  - 16 beats 39,25,84,…,0b,32; m_last only on 32.
  - blk_count=1; m_valid=0 afterwards.
- Backpressure: same block, m_ready toggling 1,0,0,1,…
  - m_data holds while m_ready=0.
  - Beat sequence is identical to the single-block case; no duplicated or skipped beats.
- Back-to-back: three edges spaced 4 cycles apart (blocks A, B, C), m_ready=1, DEPTH=2.
  - All 48 beats in order A, B, C with no gap between blocks.
  - overflow stays 0; blk_count=3.
- Overflow: m_ready=0, four edges (blocks A–D).
  - A is loaded, B and C are buffered, D is dropped; overflow=1.
  - After m_ready=1, exactly A, B, C are output; blk_count=3.
- Reset behaviour:
  - blk_valid held 1 through reset release → no capture, m_valid=0.
  - Assert reset during beat 7 of a block → all outputs 0 immediately (async). After release, no beats until a new 0→1 edge.
- OUT_W=32 build: one block → 4 beats 3925841d, 02dc09fb, dc118597, 196a0b32; m_last on the 4th.
